// File: rtl/cmd_mem_loader.sv
// cmd_mem_loader
//   Fill stage for the per-core command memory. Host words arrive over a
//   valid/ready stream and are packed, first word in the least significant
//   slot, into CMD_WIDTH commands. Each finished command is written to
//   consecutive memory addresses starting at base_addr. A load is framed by
//   start/num_cmds and ends with a one-cycle done pulse, unless it is aborted.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin a load (sampled only when idle)
//   base_addr      first write address, latched on accepted start
//   num_cmds       number of commands in the load, latched on accepted start
//   abort          cancel the load in progress; the partial command is dropped
//   word_in        host data word
//   word_valid     word_in is valid
//   word_ready     loader accepts word_in this cycle
//   write_enable   command memory write strobe (one cycle per command)
//   write_address  command memory write address
//   cmd_data       packed command for the memory write-data input
//   busy           load in progress
//   done           one-cycle pulse when the last command is written
//
// State | Meaning
// IDLE  | waiting for start; zero-count start only pulses done
// LOAD  | accepting words, writing one command per WORDS_PER_CMD accepts
module cmd_mem_loader #(
  parameter int CMD_WIDTH  = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_cmds,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [CMD_WIDTH-1:0]  cmd_data,
  output logic                  busy,
  output logic                  done
);

  localparam int WORDS_PER_CMD = CMD_WIDTH / WORD_WIDTH;
  localparam int IDX_W = (WORDS_PER_CMD > 1) ? $clog2(WORDS_PER_CMD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_CMD - 1);
  localparam logic [ADDR_WIDTH:0] ONE_CMD = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cmds_left_q, cmds_left_d;
  logic [IDX_W-1:0]      word_idx_q, word_idx_d;
  logic [CMD_WIDTH-1:0]  asm_q, asm_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cmds_left_q <= '0;
      word_idx_q  <= '0;
      asm_q       <= '0;
      we_q        <= 1'b0;
      wa_q        <= '0;
      cmd_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmds_left_q <= cmds_left_d;
      word_idx_q  <= word_idx_d;
      asm_q       <= asm_d;
      we_q        <= we_d;
      wa_q        <= wa_d;
      cmd_q       <= cmd_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cmds_left_d = cmds_left_q;
    word_idx_d  = word_idx_q;
    asm_d       = asm_q;
    we_d        = 1'b0;
    wa_d        = wa_q;
    cmd_d       = cmd_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_cmds != '0) begin
            state_d     = LOAD;
            addr_d      = base_addr;
            cmds_left_d = num_cmds;
            word_idx_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (abort) begin
          // Partial command is dropped; the next load restarts at slot 0.
          state_d    = IDLE;
          word_idx_d = '0;
        end else if (word_valid) begin
          asm_d[int'(word_idx_q) * WORD_WIDTH +: WORD_WIDTH] = word_in;
          if (word_idx_q == LAST_IDX) begin
            we_d        = 1'b1;
            wa_d        = addr_q;
            cmd_d       = asm_d;
            addr_d      = addr_q + 1'b1;
            word_idx_d  = '0;
            cmds_left_d = cmds_left_q - 1'b1;
            if (cmds_left_q == ONE_CMD) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            word_idx_d = word_idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Ready and busy are the LOAD state flop itself, so ready stays high on
  // write cycles and drops together with the final write.
  assign word_ready    = (state_q == LOAD);
  assign busy          = (state_q == LOAD);
  assign write_enable  = we_q;
  assign write_address = wa_q;
  assign cmd_data      = cmd_q;
  assign done          = done_q;

endmodule
